// File: rtl/coin_accum_pkg.sv
// coin_accum_pkg
//   Shared definitions for the coin accumulator: coin values in farthing
//   units, credit width/limit, default item price, the controller state
//   enum and a helper that maps the coin inputs to a value.
package coin_accum_pkg;

  localparam int unsigned CREDIT_W = 4;

  localparam logic [3:0] FARTHING_VAL = 4'd1;
  localparam logic [3:0] HALF_VAL     = 4'd2;
  localparam logic [3:0] PENNY_VAL    = 4'd4;

  // Largest credit the 4-bit register can hold without wrapping.
  localparam logic [4:0] CREDIT_MAX = 5'd15;

  localparam int DEFAULT_PRICE = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } state_e;

  // Value of the inserted coin. Only meaningful when exactly one input is
  // high; callers qualify it with their own single-coin check.
  function automatic logic [3:0] coin_value(input logic farthing,
                                            input logic half,
                                            input logic penny);
    logic [3:0] val;
    val = 4'd0;
    if (farthing) val = val | FARTHING_VAL;
    if (half)     val = val | HALF_VAL;
    if (penny)    val = val | PENNY_VAL;
    return val;
  endfunction

endpackage

// File: rtl/coin_accum_idle_timer.sv
// coin_accum_idle_timer
//   Idle counter for the accumulator. Counts enabled cycles from zero and
//   raises a terminal-count flag at TIMEOUT_CYCLES-1, where it stops.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   clear_i   return the count to zero (wins over enable)
//   en_i      advance the count by one
//   tc_o      count equals TIMEOUT_CYCLES-1
module coin_accum_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  // Saturates at the terminal count so a held-off timeout (coin activity
  // that was not accepted) cannot wrap the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/coin_accum.sv
// coin_accum
//   Coin acceptor controller. Accumulates farthing/halfpenny/penny pulses
//   into a credit, requests a vend once the credit reaches PRICE, and
//   refunds the held credit after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk            clock, rising edge
//   reset          synchronous active-high reset
//   coin_farthing  pulse, 1 unit inserted
//   coin_half      pulse, 2 units inserted
//   coin_penny     pulse, 4 units inserted
//   vend_ack       pulse, item and change issued (honoured only in VEND)
//   credit         accumulated credit in farthing units
//   vend_req       high while a vend is pending
//   refund_req     one-cycle pulse, return refund_amt
//   refund_amt     refund value, nonzero only with refund_req
//   coin_reject    one-cycle pulse, previous cycle's coin was not accepted
// All outputs come straight from flops.
module coin_accum
  import coin_accum_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int PRICE          = DEFAULT_PRICE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_farthing,
  input  logic       coin_half,
  input  logic       coin_penny,
  input  logic       vend_ack,
  output logic [3:0] credit,
  output logic       vend_req,
  output logic       refund_req,
  output logic [3:0] refund_amt,
  output logic       coin_reject
);

  localparam logic [4:0] PRICE_W = 5'(PRICE);

  state_e     state_q,       state_d;
  logic [3:0] credit_q,      credit_d;
  logic       vend_req_q,    vend_req_d;
  logic       refund_req_q,  refund_req_d;
  logic [3:0] refund_amt_q,  refund_amt_d;
  logic       coin_reject_q, coin_reject_d;

  logic       any_coin;
  logic       one_coin;
  logic [3:0] coin_val;
  logic [4:0] sum;
  logic       accepted;
  logic       tmr_clear;
  logic       tmr_en;
  logic       tmr_tc;

  // True when adding the coin keeps the credit inside the 4-bit register.
  function automatic logic credit_fits(input logic [4:0] total);
    return total <= CREDIT_MAX;
  endfunction

  assign any_coin = coin_farthing | coin_half | coin_penny;
  assign one_coin = (coin_farthing ^ coin_half ^ coin_penny) &
                    ~(coin_farthing & coin_half & coin_penny);
  assign coin_val = coin_value(coin_farthing, coin_half, coin_penny);
  assign sum      = {1'b0, credit_q} + {1'b0, coin_val};

  coin_accum_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear_i(tmr_clear),
    .en_i   (tmr_en),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    refund_req_d  = 1'b0;
    refund_amt_d  = 4'd0;
    coin_reject_d = 1'b0;
    accepted      = 1'b0;
    tmr_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        credit_d = 4'd0;
        if (one_coin) begin
          accepted = 1'b1;
          credit_d = coin_val;
          state_d  = ({1'b0, coin_val} >= PRICE_W) ? ST_VEND : ST_ACCUM;
        end else if (any_coin) begin
          coin_reject_d = 1'b1;
        end
      end

      ST_ACCUM: begin
        if (one_coin && credit_fits(sum)) begin
          // An accepted coin also beats a timeout landing in the same cycle.
          accepted = 1'b1;
          credit_d = sum[3:0];
          if (sum >= PRICE_W) state_d = ST_VEND;
        end else if (any_coin) begin
          // Rejected activity holds the idle count rather than clearing it.
          coin_reject_d = 1'b1;
        end else if (tmr_tc) begin
          state_d      = ST_REFUND;
          refund_req_d = 1'b1;
          refund_amt_d = credit_q;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_VEND: begin
        if (any_coin) coin_reject_d = 1'b1;
        if (vend_ack) begin
          credit_d = 4'd0;
          state_d  = ST_IDLE;
        end
      end

      ST_REFUND: begin
        // Credit stays visible during the refund cycle, then clears.
        if (any_coin) coin_reject_d = 1'b1;
        credit_d = 4'd0;
        state_d  = ST_IDLE;
      end

      default: begin
        credit_d = 4'd0;
        state_d  = ST_IDLE;
      end
    endcase

    vend_req_d = (state_d == ST_VEND);
    tmr_clear  = accepted || (state_d != ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= 4'd0;
      vend_req_q    <= 1'b0;
      refund_req_q  <= 1'b0;
      refund_amt_q  <= 4'd0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_req_q    <= vend_req_d;
      refund_req_q  <= refund_req_d;
      refund_amt_q  <= refund_amt_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign credit      = credit_q;
  assign vend_req    = vend_req_q;
  assign refund_req  = refund_req_q;
  assign refund_amt  = refund_amt_q;
  assign coin_reject = coin_reject_q;

endmodule

// File: tb/tb_coin_accum.sv
// tb_coin_accum
//   Randomised and directed stimulus for coin_accum, compared every cycle
//   against a behavioural vending-machine model kept in plain integers.
module tb_coin_accum;

  localparam int T     = 16;
  localparam int PRICE = 5;

  localparam int M_IDLE   = 0;
  localparam int M_ACCUM  = 1;
  localparam int M_VEND   = 2;
  localparam int M_REFUND = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_farthing = 1'b0;
  logic       coin_half = 1'b0;
  logic       coin_penny = 1'b0;
  logic       vend_ack = 1'b0;
  logic [3:0] credit;
  logic       vend_req;
  logic       refund_req;
  logic [3:0] refund_amt;
  logic       coin_reject;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: machine mode, credit held, idle cycles spent in ACCUM.
  int m_mode   = M_IDLE;
  int m_credit = 0;
  int m_idle   = 0;
  int m_vend   = 0;
  int m_refund = 0;
  int m_amt    = 0;
  int m_reject = 0;

  always #5 clk = ~clk;

  coin_accum #(
    .TIMEOUT_CYCLES(T),
    .PRICE         (PRICE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_farthing(coin_farthing),
    .coin_half    (coin_half),
    .coin_penny   (coin_penny),
    .vend_ack     (vend_ack),
    .credit       (credit),
    .vend_req     (vend_req),
    .refund_req   (refund_req),
    .refund_amt   (refund_amt),
    .coin_reject  (coin_reject)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // One clock of the customer-facing rules, applied at a rising edge.
  task automatic model_edge(input int f, input int h, input int p,
                            input int ack, input int rst);
    int n;
    int val;
    n   = f + h + p;
    val = f * 1 + h * 2 + p * 4;
    m_reject = 0;
    m_refund = 0;
    m_amt    = 0;
    if (rst != 0) begin
      m_mode = M_IDLE; m_credit = 0; m_idle = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (n == 1) begin
            m_credit = val;
            m_idle   = 0;
            m_mode   = (val >= PRICE) ? M_VEND : M_ACCUM;
          end else if (n > 1) m_reject = 1;
        end
        M_ACCUM: begin
          if (n == 1 && m_credit + val <= 15) begin
            m_credit += val;
            m_idle = 0;
            if (m_credit >= PRICE) m_mode = M_VEND;
          end else if (n > 0) begin
            m_reject = 1;
          end else if (m_idle == T - 1) begin
            m_mode = M_REFUND; m_refund = 1; m_amt = m_credit; m_idle = 0;
          end else begin
            m_idle++;
          end
        end
        M_VEND: begin
          if (n > 0) m_reject = 1;
          if (ack != 0) begin m_credit = 0; m_mode = M_IDLE; end
        end
        default: begin
          if (n > 0) m_reject = 1;
          m_credit = 0; m_mode = M_IDLE;
        end
      endcase
    end
    m_vend = (m_mode == M_VEND) ? 1 : 0;
  endtask

  task automatic step(input logic f, input logic h, input logic p,
                      input logic ack, input logic rst);
    @(negedge clk);
    coin_farthing = f; coin_half = h; coin_penny = p;
    vend_ack = ack; reset = rst;
    @(posedge clk);
    model_edge(int'(f), int'(h), int'(p), int'(ack), int'(rst));
    #1;
    check("credit",      int'(credit),      m_credit);
    check("vend_req",    int'(vend_req),    m_vend);
    check("refund_req",  int'(refund_req),  m_refund);
    check("refund_amt",  int'(refund_amt),  m_amt);
    check("coin_reject", int'(coin_reject), m_reject);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("rst_credit", int'(credit), 0);
    check("rst_reject", int'(coin_reject), 0);

    // Penny + farthing reaches the price
    step(0, 0, 1, 0, 0);
    check("pf_credit4", int'(credit), 4);
    step(1, 0, 0, 0, 0);
    check("pf_credit5", int'(credit), 5);
    check("pf_vend", int'(vend_req), 1);
    idle(2);
    step(0, 0, 0, 1, 0);
    check("pf_ack_credit", int'(credit), 0);
    check("pf_ack_vend", int'(vend_req), 0);

    // Half, half, penny overshoots to 8
    step(0, 1, 0, 0, 0);
    check("hhp_2", int'(credit), 2);
    step(0, 1, 0, 0, 0);
    check("hhp_4", int'(credit), 4);
    step(0, 0, 1, 0, 0);
    check("hhp_8", int'(credit), 8);
    check("hhp_vend", int'(vend_req), 1);
    step(0, 0, 0, 1, 0);

    // Farthing, then timeout refunds 1
    step(1, 0, 0, 0, 0);
    idle(T - 1);
    check("to_early", int'(refund_req), 0);
    step(0, 0, 0, 0, 0);
    check("to_refund", int'(refund_req), 1);
    check("to_amt", int'(refund_amt), 1);
    step(0, 0, 0, 0, 0);
    check("to_pulse", int'(refund_req), 0);
    check("to_credit", int'(credit), 0);

    // Double coin at credit 1 is rejected
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    check("dbl_reject", int'(coin_reject), 1);
    check("dbl_credit", int'(credit), 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // Coin during VEND at credit 6
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    check("vc_reject", int'(coin_reject), 1);
    check("vc_credit", int'(credit), 6);
    step(0, 0, 0, 1, 0);
    check("vc_idle", int'(credit), 0);

    // Reset in VEND at credit 7, with a coincident farthing
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("rv_credit7", int'(credit), 7);
    step(1, 0, 0, 0, 1);
    check("rv_credit", int'(credit), 0);
    check("rv_vend", int'(vend_req), 0);
    check("rv_reject", int'(coin_reject), 0);
    step(0, 0, 0, 0, 0);
    check("rv_norefund", int'(refund_req), 0);

    // Coin in the timeout cycle wins
    step(1, 0, 0, 0, 0);
    idle(T - 1);
    step(1, 0, 0, 0, 0);
    check("ct_refund", int'(refund_req), 0);
    check("ct_credit", int'(credit), 2);
    idle(T);
    check("ct_late_amt", int'(refund_amt), 2);
    step(0, 0, 0, 0, 0);

    // Random traffic, alternating busy and quiet phases
    for (int i = 0; i < 4000; i++) begin
      int busy;
      int pct;
      logic [2:0] c;
      busy = ((i / 200) % 2 == 0) ? 1 : 0;
      pct  = busy ? 35 : 4;
      c = 3'b000;
      if ($urandom_range(99) < pct) c = 3'($urandom_range(7, 1));
      step(c[0], c[1], c[2], $urandom_range(3) == 0,
           $urandom_range(299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coin_accum.md
COIN_ACCUM -- requirements
Module: coin_accum

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, idle cycles in ACCUM before the held credit is refunded.
REQ-002 Parameter PRICE, default 5, item price in farthing units.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 coin_farthing  input  1  one-cycle pulse, farthing inserted (1 unit).
REQ-006 coin_half  input  1  one-cycle pulse, halfpenny inserted (2 units).
REQ-007 coin_penny  input  1  one-cycle pulse, penny inserted (4 units).
REQ-008 vend_ack  input  1  one-cycle pulse from dispense side: item and change issued.
REQ-009 credit  output  4  accumulated credit in farthing units; drives the dispense decoder's 4-bit credit input.
REQ-010 vend_req  output  1  high while credit >= PRICE and awaiting vend_ack.
REQ-011 refund_req  output  1  one-cycle pulse, return refund_amt to customer.
REQ-012 refund_amt  output  4  units to return; valid only with refund_req.
REQ-013 coin_reject  output  1  one-cycle pulse, coin inserted this cycle was not accepted (returned by the mechanism).

Function
REQ-014 States SHALL be IDLE, ACCUM, VEND, REFUND.
REQ-015 IDLE: credit = 0; one valid coin pulse -> credit = coin value, go to ACCUM next cycle.
REQ-016 ACCUM: each valid coin adds its value to credit on the same edge; idle counter clears on every accepted coin.
REQ-017 ACCUM -> VEND on the edge where updated credit >= PRICE; vend_req high from the next cycle.
REQ-018 ACCUM -> REFUND when idle counter reaches TIMEOUT_CYCLES-1 with no coin that cycle.
REQ-019 VEND: credit held constant; vend_req high; on vend_ack, credit clears to 0 and state goes to IDLE next cycle.
REQ-020 REFUND: single cycle; refund_req = 1, refund_amt = credit; credit clears to 0; then IDLE.
REQ-021 Valid coin = exactly one of the three coin inputs high in a cycle.
REQ-022 Two or more coin inputs high in one cycle: none accepted, coin_reject pulses next cycle, credit and state unchanged, idle counter not cleared.
REQ-023 Any coin pulse in VEND or REFUND: not accepted, coin_reject pulses next cycle.
REQ-024 Credit never exceeds 8 with PRICE = 5 (max 4 before final coin); width 4 bits, no wrap; a coin that would make credit > 15 for other PRICE values SHALL be rejected.
REQ-025 vend_ack outside VEND SHALL be ignored.
REQ-026 Coin and timeout in same cycle in ACCUM: coin wins, counter clears, no refund.
REQ-027 vend_req, refund_req, coin_reject are registered outputs; no combinational path from inputs.

Reset
REQ-028 reset high on a clock edge SHALL force IDLE, credit = 0, idle counter = 0, vend_req = 0, refund_req = 0, refund_amt = 0, coin_reject = 0.
REQ-029 Reset during ACCUM or VEND discards held credit; no refund_req issued.
REQ-030 Coin pulses coincident with reset SHALL be ignored, no coin_reject.

Structure
REQ-031 Shared package SHALL hold coin value constants (1, 2, 4), default PRICE, and the state enum.
REQ-032 One sub-module, idle_timer (counter with clear/enable, terminal-count flag, width from TIMEOUT_CYCLES), is natural; remainder is one FSM plus credit register.

Verification
REQ-033 Reset, then penny, farthing -> credit 4 then 5, vend_req high one cycle after second coin; vend_ack -> credit 0, IDLE.
REQ-034 Half, half, penny -> credit 2, 4, 8, vend_req high; dispense side sees credit = 8.
REQ-035 Farthing then no coin for TIMEOUT_CYCLES (use 16) -> refund_req single pulse with refund_amt = 1, credit 0.
REQ-036 coin_half and coin_penny together in ACCUM at credit 1 -> coin_reject pulse, credit stays 1.
REQ-037 In VEND at credit 6, farthing pulse -> coin_reject, credit stays 6; vend_ack -> IDLE.
REQ-038 reset asserted in VEND at credit 7 -> all outputs 0 next cycle, no refund_req; farthing coincident with TIMEOUT_CYCLES-1 -> accepted, no refund.
